// File: rtl/arbiter_rr_n.sv
// Registered N-way arbiter with run-time fixed/round-robin policy and a
// bounded grant tenure. Outputs are pure flops; req never reaches them combinationally.

module arbiter_rr_n_lane #(
  parameter int IDW = 2,
  parameter int IDX = 0
) (
  input  logic           req_bit,
  input  logic [IDW-1:0] ptr,
  output logic           hi
);
  // Lane sits at or above the round-robin start point.
  assign hi = req_bit && (ptr <= IDW'(IDX));
endmodule

module arbiter_rr_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [N-1:0]  ONE = N'(1);

  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [N-1:0]   req_hi;
  logic [IDW-1:0] w_lo, w_hi, win, ptr_nxt;
  logic           found, found_hi, keep;

  for (genvar i = 0; i < N; i++) begin : g_lane
    arbiter_rr_n_lane #(.IDW(IDW), .IDX(i)) u_lane (
      .req_bit(req[i]),
      .ptr    (ptr),
      .hi     (req_hi[i])
    );
  end

  // Lowest set index of the full vector and of the ptr-masked vector;
  // the masked one wins in round-robin, wrapping to the full one if empty.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i])    w_lo = IDW'(i);
      if (req_hi[i]) w_hi = IDW'(i);
    end
    found    = |req;
    found_hi = |req_hi;
    win      = (mode && found_hi) ? w_hi : w_lo;
    ptr_nxt  = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
    keep     = gnt_valid && req[gnt_id] && ((MAX_HOLD == 0) || (hold_cnt != HOLD_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else if (keep) begin
      hold_cnt  <= hold_cnt + HW'(1);
    end else begin
      gnt       <= found ? (ONE << win) : '0;
      gnt_valid <= found;
      gnt_id    <= found ? win : '0;
      hold_cnt  <= '0;
      if (found) ptr <= ptr_nxt;
    end
  end
endmodule
